// File: rtl/gpio_pkg.sv
// Shared constants for the parametrised GPIO controller: register byte offsets,
// version code and the supported pin-count ceiling.
package gpio_pkg;

  localparam int NPIN_MAX = 32;

  localparam logic [7:0] VERSION = 8'h01;

  localparam logic [7:0] OFS_DOUT  = 8'h00;
  localparam logic [7:0] OFS_DIR   = 8'h04;
  localparam logic [7:0] OFS_DIN   = 8'h08;
  localparam logic [7:0] OFS_SET   = 8'h0C;
  localparam logic [7:0] OFS_CLR   = 8'h10;
  localparam logic [7:0] OFS_TGL   = 8'h14;
  localparam logic [7:0] OFS_IEN   = 8'h18;
  localparam logic [7:0] OFS_IRISE = 8'h1C;
  localparam logic [7:0] OFS_IFALL = 8'h20;
  localparam logic [7:0] OFS_ISTAT = 8'h24;
  localparam logic [7:0] OFS_INFO  = 8'h28;

endpackage

// File: rtl/gpio_in_filter.sv
// Input conditioning for the GPIO pins: two-flop synchroniser followed by a
// tick-driven debounce that only accepts two consecutive equal samples.
module gpio_in_filter
  import gpio_pkg::*;
#(
  parameter int NPIN    = 16,
  parameter int DEB_DIV = 1000,
  parameter int DEB_W   = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NPIN-1:0] pin_i,
  output logic [NPIN-1:0] filt_o
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'((DEB_DIV > 0) ? (DEB_DIV - 1) : 0);

  logic [NPIN-1:0]  sync1_d, sync1_q;
  logic [NPIN-1:0]  sync2_d, sync2_q;
  logic [NPIN-1:0]  samp_d, samp_q;
  logic [NPIN-1:0]  filt_d, filt_q;
  logic [NPIN-1:0]  agree_s;
  logic [DEB_W-1:0] cnt_d, cnt_q;
  logic             tick_s;

  assign agree_s = ~(sync2_q ^ samp_q);

  // Next-state: free-running tick counter and per-pin debounce acceptance
  always_comb begin
    sync1_d = pin_i;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    samp_d  = samp_q;
    filt_d  = filt_q;
    tick_s  = 1'b0;
    if (DEB_DIV == 0) begin
      filt_d = sync2_q;
    end else begin
      if (cnt_q == DEB_LAST) begin
        tick_s = 1'b1;
        cnt_d  = {DEB_W{1'b0}};
      end else begin
        tick_s = 1'b0;
        cnt_d  = cnt_q + DEB_W'(1);
      end
      // A pin only moves when the new sample matches the previous one
      if (tick_s) begin
        samp_d = sync2_q;
        filt_d = (samp_q & agree_s) | (filt_q & ~agree_s);
      end else begin
        samp_d = samp_q;
        filt_d = filt_q;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= {NPIN{1'b0}};
      sync2_q <= {NPIN{1'b0}};
      samp_q  <= {NPIN{1'b0}};
      filt_q  <= {NPIN{1'b0}};
      cnt_q   <= {DEB_W{1'b0}};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      samp_q  <= samp_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/gpio_ctrl_n.sv
// NPIN-bit memory-mapped GPIO: direction, atomic set/clear/toggle, filtered
// inputs with rise/fall edge capture and a maskable level interrupt.
module gpio_ctrl_n
  import gpio_pkg::*;
#(
  parameter int              NPIN      = 16,
  parameter logic [15:0]     BASE_ADDR = 16'h7F00,
  parameter int              DEB_DIV   = 1000,
  parameter int              DEB_W     = 10,
  parameter logic [NPIN-1:0] OUT_RST   = {NPIN{1'b0}}
) (
  input  logic            inclk,
  input  logic            inrst,
  input  logic [15:0]     addr,
  input  logic [31:0]     wdata,
  input  logic            we,
  input  logic            re,
  output logic [31:0]     rdata,
  input  logic [NPIN-1:0] gpio_in,
  output logic [NPIN-1:0] gpio_out,
  output logic [NPIN-1:0] gpio_oe,
  output logic            irq
);

  localparam logic [7:0] NPIN_B = 8'(NPIN);

  logic [NPIN-1:0] dout_d, dout_q;
  logic [NPIN-1:0] dir_d, dir_q;
  logic [NPIN-1:0] ien_d, ien_q;
  logic [NPIN-1:0] irise_d, irise_q;
  logic [NPIN-1:0] ifall_d, ifall_q;
  logic [NPIN-1:0] istat_d, istat_q;
  logic [NPIN-1:0] filt_s, filt_dly_q;
  logic [NPIN-1:0] ev_s, w1c_s, wval_s;
  logic [31:0]     rdata_d, rdata_q;
  logic [7:0]      ofs_s;
  logic            hit_s;
  logic            unused_s;

  gpio_in_filter #(
    .NPIN    (NPIN),
    .DEB_DIV (DEB_DIV),
    .DEB_W   (DEB_W)
  ) u_filter (
    .clk    (inclk),
    .rst_n  (inrst),
    .pin_i  (gpio_in),
    .filt_o (filt_s)
  );

  assign hit_s    = (addr[15:8] == BASE_ADDR[15:8]);
  assign ofs_s    = {addr[7:2], 2'b00};
  assign wval_s   = wdata[NPIN-1:0];
  assign unused_s = ^{addr[1:0], wdata};

  // Edges are judged against the previous filtered value
  assign ev_s = (filt_s & ~filt_dly_q & irise_q) | (~filt_s & filt_dly_q & ifall_q);

  // Register writes; a fresh event outranks a same-cycle W1C on its bit
  always_comb begin
    dout_d  = dout_q;
    dir_d   = dir_q;
    ien_d   = ien_q;
    irise_d = irise_q;
    ifall_d = ifall_q;
    w1c_s   = {NPIN{1'b0}};
    if (we && hit_s) begin
      case (ofs_s)
        OFS_DOUT:  dout_d  = wval_s;
        OFS_DIR:   dir_d   = wval_s;
        OFS_SET:   dout_d  = dout_q | wval_s;
        OFS_CLR:   dout_d  = dout_q & ~wval_s;
        OFS_TGL:   dout_d  = dout_q ^ wval_s;
        OFS_IEN:   ien_d   = wval_s;
        OFS_IRISE: irise_d = wval_s;
        OFS_IFALL: ifall_d = wval_s;
        OFS_ISTAT: w1c_s   = wval_s;
        default:   w1c_s   = {NPIN{1'b0}};
      endcase
    end else begin
      w1c_s = {NPIN{1'b0}};
    end
    istat_d = (istat_q & ~w1c_s) | ev_s;
  end

  // Read mux sees pre-write register values; rdata holds between reads
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      if (hit_s) begin
        case (ofs_s)
          OFS_DOUT:  rdata_d = 32'(dout_q);
          OFS_DIR:   rdata_d = 32'(dir_q);
          OFS_DIN:   rdata_d = 32'(filt_s);
          OFS_IEN:   rdata_d = 32'(ien_q);
          OFS_IRISE: rdata_d = 32'(irise_q);
          OFS_IFALL: rdata_d = 32'(ifall_q);
          OFS_ISTAT: rdata_d = 32'(istat_q);
          OFS_INFO:  rdata_d = {16'h0000, VERSION, NPIN_B};
          default:   rdata_d = 32'h0000_0000;
        endcase
      end else begin
        rdata_d = 32'h0000_0000;
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Register file and edge-history flops
  always_ff @(posedge inclk) begin
    if (!inrst) begin
      dout_q     <= OUT_RST;
      dir_q      <= {NPIN{1'b0}};
      ien_q      <= {NPIN{1'b0}};
      irise_q    <= {NPIN{1'b0}};
      ifall_q    <= {NPIN{1'b0}};
      istat_q    <= {NPIN{1'b0}};
      filt_dly_q <= {NPIN{1'b0}};
      rdata_q    <= 32'h0000_0000;
    end else begin
      dout_q     <= dout_d;
      dir_q      <= dir_d;
      ien_q      <= ien_d;
      irise_q    <= irise_d;
      ifall_q    <= ifall_d;
      istat_q    <= istat_d;
      filt_dly_q <= filt_s;
      rdata_q    <= rdata_d;
    end
  end

  assign rdata    = rdata_q;
  assign gpio_out = dout_q;
  assign gpio_oe  = dir_q;
  assign irq      = |(istat_q & ien_q);

endmodule

// File: tb/tb_gpio_ctrl_n.sv
// Bench for gpio_ctrl_n: one instance without debounce (checked every cycle
// against a delay-line reference model) and one with DEB_DIV = 4.
module tb_gpio_ctrl_n;

  localparam int          NP      = 16;
  localparam logic [15:0] BASE    = 16'h7F00;
  localparam logic [15:0] RST_VAL = 16'h00A5;

  logic          inclk = 1'b0;
  logic          inrst;
  logic [15:0]   addr;
  logic [31:0]   wdata;
  logic          we, re;
  logic [NP-1:0] gin_a, gin_b, gout_a, gout_b, goe_a, goe_b;
  logic [31:0]   rdata_a, rdata_b;
  logic          irq_a, irq_b;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [NP-1:0] m_dout, m_dir, m_en, m_rise, m_fall, m_stat;
  logic [31:0]   m_rdata;
  logic [NP-1:0] hist [0:3];

  always #5 inclk = ~inclk;

  gpio_ctrl_n #(.NPIN(NP), .BASE_ADDR(BASE), .DEB_DIV(0), .DEB_W(1), .OUT_RST(RST_VAL)) dut_a (
    .inclk(inclk), .inrst(inrst), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata_a), .gpio_in(gin_a), .gpio_out(gout_a), .gpio_oe(goe_a), .irq(irq_a));

  gpio_ctrl_n #(.NPIN(NP), .BASE_ADDR(BASE), .DEB_DIV(4), .DEB_W(3), .OUT_RST(RST_VAL)) dut_b (
    .inclk(inclk), .inrst(inrst), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata_b), .gpio_in(gin_b), .gpio_out(gout_b), .gpio_oe(goe_b), .irq(irq_b));

  function automatic logic [31:0] model_read(input logic [15:0] a, input logic [NP-1:0] din);
    logic [31:0] v;
    v = 32'h0;
    if (a[15:8] == 8'h7F) begin
      case ({a[7:2], 2'b00})
        8'h00:   v = 32'(m_dout);
        8'h04:   v = 32'(m_dir);
        8'h08:   v = 32'(din);
        8'h18:   v = 32'(m_en);
        8'h1C:   v = 32'(m_rise);
        8'h20:   v = 32'(m_fall);
        8'h24:   v = 32'(m_stat);
        8'h28:   v = 32'h0000_0100 | 32'(NP);
        default: v = 32'h0;
      endcase
    end
    return v;
  endfunction

  task automatic drive(input logic w, input logic r, input logic [15:0] a, input logic [31:0] d);
    we = w; re = r; addr = a; wdata = d;
  endtask

  // One clock: the filtered input of instance a is the pin value three edges
  // back; an edge becomes status one edge after it shows in the filtered value.
  task automatic step();
    logic [NP-1:0] fnow, fprev, ev, w1c, wv, s_gin;
    logic [15:0]   s_addr;
    logic [31:0]   s_wdata;
    logic          s_we, s_re, s_rst, hit;
    s_we = we; s_re = re; s_rst = inrst; s_addr = addr; s_wdata = wdata; s_gin = gin_a;
    @(posedge inclk);
    if (!s_rst) begin
      m_dout = RST_VAL; m_dir = 16'h0; m_en = 16'h0; m_rise = 16'h0; m_fall = 16'h0;
      m_stat = 16'h0; m_rdata = 32'h0;
      for (int i = 0; i < 4; i++) hist[i] = 16'h0;
    end else begin
      fnow  = hist[2];
      fprev = hist[3];
      ev    = (fnow & ~fprev & m_rise) | (~fnow & fprev & m_fall);
      if (s_re) m_rdata = model_read(s_addr, fnow);
      hit = (s_addr[15:8] == 8'h7F);
      wv  = s_wdata[NP-1:0];
      w1c = 16'h0;
      if (s_we && hit) begin
        case ({s_addr[7:2], 2'b00})
          8'h00:   m_dout = wv;
          8'h04:   m_dir = wv;
          8'h0C:   m_dout = m_dout | wv;
          8'h10:   m_dout = m_dout & ~wv;
          8'h14:   m_dout = m_dout ^ wv;
          8'h18:   m_en = wv;
          8'h1C:   m_rise = wv;
          8'h20:   m_fall = wv;
          8'h24:   w1c = wv;
          default: ;
        endcase
      end
      m_stat  = (m_stat & ~w1c) | ev;
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = s_gin;
    end
    @(negedge inclk);
  endtask

  task automatic test_reset();
    inrst = 1'b0; gin_a = 16'h0; gin_b = 16'h0;
    drive(1'b0, 1'b0, 16'h0000, 32'h0);
    for (int i = 0; i < 3; i++) step();
    inrst = 1'b1;
    checks++; if (gout_a !== 16'h00A5) begin errors++; $display("FAIL reset_out_a: got %h expected 00a5", gout_a); end
    checks++; if (gout_b !== 16'h00A5) begin errors++; $display("FAIL reset_out_b: got %h expected 00a5", gout_b); end
    checks++; if (goe_a !== 16'h0) begin errors++; $display("FAIL reset_oe: got %h expected 0000", goe_a); end
    checks++; if (irq_a !== 1'b0 || irq_b !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b%b expected 00", irq_a, irq_b); end
    checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata_a); end
    drive(1'b0, 1'b1, BASE | 16'h0004, 32'h0); step();
    checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL reset_dir_read: got %h expected 0", rdata_a); end
    drive(1'b0, 1'b1, BASE | 16'h0024, 32'h0); step();
    checks++; if (rdata_b !== 32'h0) begin errors++; $display("FAIL reset_stat_read: got %h expected 0", rdata_b); end
  endtask

  task automatic test_atomic();
    logic [15:0] ofs [0:3];
    logic [31:0] dat [0:3];
    logic [15:0] exp [0:3];
    ofs[0] = 16'h00; dat[0] = 32'h00F0; exp[0] = 16'h00F0;
    ofs[1] = 16'h0C; dat[1] = 32'h000F; exp[1] = 16'h00FF;
    ofs[2] = 16'h10; dat[2] = 32'h0030; exp[2] = 16'h00CF;
    ofs[3] = 16'h14; dat[3] = 32'h0101; exp[3] = 16'h01CE;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, BASE | ofs[i], dat[i]); step();
      checks++; if (gout_a !== exp[i] || gout_b !== exp[i]) begin
        errors++; $display("FAIL atomic_out_%0d: got %h/%h expected %h", i, gout_a, gout_b, exp[i]);
      end
    end
    drive(1'b0, 1'b1, BASE, 32'h0); step();
    checks++; if (rdata_a !== 32'h0000_01CE) begin errors++; $display("FAIL atomic_readback: got %h expected 000001ce", rdata_a); end
    drive(1'b0, 1'b1, BASE | 16'h000C, 32'h0); step();
    checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL set_reads_zero: got %h expected 0", rdata_a); end
    drive(1'b1, 1'b1, BASE, 32'h0000_1234); step();
    checks++; if (rdata_a !== 32'h0000_01CE) begin errors++; $display("FAIL rw_same_cycle: got %h expected 000001ce", rdata_a); end
    checks++; if (gout_a !== 16'h1234) begin errors++; $display("FAIL rw_write: got %h expected 1234", gout_a); end
    drive(1'b0, 1'b0, BASE, 32'h0); step();
    checks++; if (rdata_a !== 32'h0000_01CE) begin errors++; $display("FAIL rdata_hold: got %h expected 000001ce", rdata_a); end
  endtask

  task automatic test_decode();
    drive(1'b1, 1'b0, BASE + 16'h0100, 32'hFFFF_FFFF); step();
    drive(1'b1, 1'b0, BASE + 16'h003C, 32'hFFFF_FFFF); step();
    checks++; if (gout_a !== 16'h1234 || goe_a !== 16'h0) begin
      errors++; $display("FAIL decode_nohit: got out %h oe %h expected 1234/0000", gout_a, goe_a);
    end
    drive(1'b0, 1'b1, BASE + 16'h0028, 32'h0); step();
    checks++; if (rdata_a !== 32'h0000_0110) begin errors++; $display("FAIL info: got %h expected 00000110", rdata_a); end
    drive(1'b0, 1'b1, BASE + 16'h0100, 32'h0); step();
    checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL read_nohit: got %h expected 0", rdata_a); end
    drive(1'b0, 1'b1, BASE + 16'h002B, 32'h0); step();
    checks++; if (rdata_a !== 32'h0000_0110) begin errors++; $display("FAIL info_lowbits: got %h expected 00000110", rdata_a); end
  endtask

  task automatic test_debounce();
    int first;
    drive(1'b0, 1'b1, BASE | 16'h0008, 32'h0);
    gin_b = 16'h0008;
    for (int i = 1; i <= 14; i++) begin
      if (i == 4) gin_b = 16'h0000;
      step();
      checks++; if (rdata_b[3] !== 1'b0) begin errors++; $display("FAIL deb_glitch_%0d: got %b expected 0", i, rdata_b[3]); end
    end
    gin_b = 16'h0008;
    first = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (rdata_b[3] === 1'b1 && first == 0) first = i;
    end
    checks++; if (first < 8 || first > 11) begin errors++; $display("FAIL deb_latency: got %0d expected 8..11", first); end
    checks++; if (rdata_b[3] !== 1'b1) begin errors++; $display("FAIL deb_stable: got %b expected 1", rdata_b[3]); end
    gin_b = 16'h0000;
    drive(1'b0, 1'b0, BASE, 32'h0);
  endtask

  task automatic test_irq();
    logic exp;
    drive(1'b1, 1'b0, BASE | 16'h001C, 32'h1); step();
    drive(1'b1, 1'b0, BASE | 16'h0018, 32'h1); step();
    drive(1'b0, 1'b0, BASE, 32'h0);
    gin_a = 16'h0001;
    for (int i = 1; i <= 5; i++) begin
      step();
      exp = (i >= 4);
      checks++; if (irq_a !== exp) begin errors++; $display("FAIL irq_timing_%0d: got %b expected %b", i, irq_a, exp); end
    end
    drive(1'b0, 1'b1, BASE | 16'h0024, 32'h0); step();
    checks++; if (rdata_a !== 32'h1) begin errors++; $display("FAIL irq_stat: got %h expected 1", rdata_a); end
    drive(1'b1, 1'b0, BASE | 16'h0024, 32'h1); step();
    checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL irq_w1c: got %b expected 0", irq_a); end
  endtask

  task automatic test_collision();
    drive(1'b1, 1'b0, BASE | 16'h0020, 32'h1); step();
    drive(1'b0, 1'b0, BASE, 32'h0);
    gin_a = 16'h0000;
    for (int i = 1; i <= 3; i++) step();
    drive(1'b1, 1'b0, BASE | 16'h0024, 32'h1); step();
    checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL collision_irq: got %b expected 1", irq_a); end
    drive(1'b0, 1'b1, BASE | 16'h0024, 32'h0); step();
    checks++; if (rdata_a !== 32'h1) begin errors++; $display("FAIL collision_stat: got %h expected 1", rdata_a); end
    drive(1'b1, 1'b0, BASE | 16'h0024, 32'h1); step();
    checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL collision_clear: got %b expected 0", irq_a); end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [7:0]  o;
    logic        exp_irq;
    for (int n = 0; n < 600; n++) begin
      o = (8'($urandom_range(0, 11)) << 2) | 8'($urandom_range(0, 3));
      a = ($urandom_range(0, 15) == 0) ? 16'($urandom) : (BASE | {8'h00, o});
      inrst = !(n >= 300 && n < 302);
      if ($urandom_range(0, 3) == 0) gin_a = gin_a ^ 16'($urandom);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
      step();
      exp_irq = |(m_stat & m_en);
      checks++; if (rdata_a !== m_rdata) begin errors++; $display("FAIL rnd_rdata_%0d: got %h expected %h", n, rdata_a, m_rdata); end
      checks++; if (gout_a !== m_dout || gout_b !== m_dout) begin
        errors++; $display("FAIL rnd_out_%0d: got %h/%h expected %h", n, gout_a, gout_b, m_dout);
      end
      checks++; if (goe_a !== m_dir) begin errors++; $display("FAIL rnd_oe_%0d: got %h expected %h", n, goe_a, m_dir); end
      checks++; if (irq_a !== exp_irq) begin errors++; $display("FAIL rnd_irq_%0d: got %b expected %b", n, irq_a, exp_irq); end
    end
    inrst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_atomic();
    test_decode();
    test_debounce();
    test_irq();
    test_collision();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl_n.md
Name: gpio_ctrl_n

Overview:
- Parametrised successor to the fixed 16-bit write-only GPIO port on the processor data bus.
- Provides NPIN bidirectional pins with per-pin direction and atomic set/clear/toggle.
- Inputs pass through a 2-flop synchroniser and a debounce filter, then feed edge detection with a maskable, level-sensitive interrupt.
- Sits on the data-memory bus (dataaddress/writedata/wenable) beside data_ram and sysreg; registered read data returns to the datapath.

Parameters:
- NPIN, 16, number of pins, 1..32.
- BASE_ADDR, 16'h7F00, bus base address, 256-byte aligned.
- DEB_DIV, 1000, debounce sample-tick period in clocks; 0 bypasses the debounce filter.
- DEB_W, 10, width of the tick counter; must satisfy 2^DEB_W > DEB_DIV.
- OUT_RST, 0, reset value of DATA_OUT (NPIN bits).

Ports:
- inclk  in  1  clock; all logic on rising edge.
- inrst  in  1  synchronous, active-low reset.
- addr  in  16  byte address.
- wdata  in  32  write data.
- we  in  1  write strobe, one access per cycle.
- re  in  1  read strobe.
- rdata  out  32  read data, valid the cycle after re.
- gpio_in  in  NPIN  asynchronous pin inputs.
- gpio_out  out  NPIN  output drive values.
- gpio_oe  out  NPIN  output enables (1 = drive).
- irq  out  1  level interrupt = |(IRQ_STAT & IRQ_EN).

Behaviour:
- Decode: hit when addr[15:8] == BASE_ADDR[15:8]; register = addr[7:2]; addr[1:0] ignored.
- Unmapped offsets: writes ignored, reads return 0.
- Only bits [NPIN-1:0] are meaningful; upper rdata bits read 0.
- Register map:
  - 0x00 DATA_OUT RW.
  - 0x04 DIR RW.
  - 0x08 DATA_IN RO; returns the filtered value.
  - 0x0C SET WO; DATA_OUT |= wdata.
  - 0x10 CLR WO; DATA_OUT &= ~wdata.
  - 0x14 TGL WO; DATA_OUT ^= wdata.
  - 0x18 IRQ_EN RW.
  - 0x1C IRQ_RISE RW.
  - 0x20 IRQ_FALL RW.
  - 0x24 IRQ_STAT RW1C.
  - 0x28 INFO RO = {16'h0, DEB_DIV-independent 8'h01 version, NPIN[7:0]}.
- Write-only registers read 0.
- Writes take effect at the clock edge; gpio_out/gpio_oe update the same edge (0 cycles after we is sampled).
- Read latency is exactly 1 cycle. rdata holds its value until the next re; re with no hit yields 0.
- Read and write to the same register in one cycle: rdata returns the pre-write value.
- Input path:
  - sync2 = two flops on gpio_in, giving 2 cycles of latency.
  - Tick counter counts 0..DEB_DIV-1 and pulses tick on wrap.
  - On tick: samp <= sync2; filt[i] <= samp[i] only if sync2[i] == samp[i], i.e. two consecutive equal samples.
  - DEB_DIV = 0: filt <= sync2 every cycle.
  - filt_d is filt delayed by 1 cycle.
  - rise = filt & ~filt_d; fall = ~filt & filt_d.
- Event: ev = (rise & IRQ_RISE) | (fall & IRQ_FALL).
- IRQ_STAT update: IRQ_STAT <= (IRQ_STAT & ~w1c) | ev.
  - When set and W1C hit the same bit in the same cycle, set wins.
- IRQ_EN masks irq only. Status still latches for disabled pins.
- irq is combinational from registers, so it asserts 1 cycle after the edge is visible in filt.
- Pins with DIR = 1 still sample gpio_in (readback of the driven pin).
- Reset (inrst = 0 at edge), applies even mid-debounce or mid-interrupt:
  - DATA_OUT = OUT_RST; DIR, IRQ_EN, IRQ_RISE, IRQ_FALL, IRQ_STAT = 0.
  - sync, samp, filt, filt_d = 0; tick counter = 0; rdata = 0.
  - Consequences: gpio_oe = 0, irq = 0.
  - A pin held high through reset produces a rising event once filtered after release (flagged only if IRQ_RISE has since been set).
- Tick counter wrap: runs freely and is never reset by bus accesses.

Decomposition:
- Shared package gpio_pkg:
  - register offset localparams (OFS_DOUT … OFS_INFO);
  - version constant;
  - NPIN upper bound (32).
- One sub-module gpio_in_filter: synchroniser, tick counter and debounce, parametrised by NPIN/DEB_DIV/DEB_W; outputs filt.
- Register file, decode and edge/IRQ logic live in gpio_ctrl_n.

Test Plan:
- Reset/defaults: hold inrst = 0 for 3 cycles with OUT_RST = 16'h00A5 → gpio_out = 0x00A5, gpio_oe = 0, irq = 0, reads of 0x04/0x24 return 0.
- Atomic ops: write DOUT = 0x00F0, SET 0x000F, CLR 0x0030, TGL 0x0101 → readback 0x01CE, gpio_out matches on the edge after each write; read of 0x0C returns 0.
- Debounce (DEB_DIV = 4): pulse gpio_in[3] high for 3 cycles → DATA_IN bit3 stays 0; hold high 12 cycles → bit3 = 1 within 2 + 2×4 cycles.
- IRQ (DEB_DIV = 0): IRQ_RISE = 0x1, IRQ_EN = 0x1, raise gpio_in[0] → IRQ_STAT = 0x1 and irq = 1 at cycle 4 after the input change; W1C 0x1 → irq = 0.
- Collision: W1C bit0 in the same cycle a new bit0 falling event occurs with IRQ_FALL = 1 → IRQ_STAT bit0 remains 1.
- Decode: write addr = BASE_ADDR + 0x100 and BASE_ADDR + 0x3C → no register changes; read of BASE_ADDR + 0x28 with NPIN = 16 returns 0x00000110.
